// File: rtl/eth_rx_fcs_check_if.sv
// Stream bundle for the receive FCS checker.
//   rx_*   : byte stream from the MAC receive path (data, valid, last, PHY error)
//   out_*  : payload stream with the 4 FCS bytes stripped
//   stat_* : one-cycle end-of-frame status strobe plus held result flags/length
// master : the side that sources rx_* and observes out_*/stat_*
// slave  : the checker itself
interface eth_rx_fcs_check_if #(
  parameter int LW = 11
);
  logic [7:0]    rx_data;
  logic          rx_valid;
  logic          rx_last;
  logic          rx_er;
  logic [7:0]    out_data;
  logic          out_valid;
  logic          out_last;
  logic          stat_valid;
  logic          stat_ok;
  logic          stat_crc_err;
  logic          stat_runt;
  logic          stat_giant;
  logic          stat_phy_err;
  logic [LW-1:0] stat_len;

  modport master (
    output rx_data, rx_valid, rx_last, rx_er,
    input  out_data, out_valid, out_last,
    input  stat_valid, stat_ok, stat_crc_err, stat_runt, stat_giant, stat_phy_err, stat_len
  );

  modport slave (
    input  rx_data, rx_valid, rx_last, rx_er,
    output out_data, out_valid, out_last,
    output stat_valid, stat_ok, stat_crc_err, stat_runt, stat_giant, stat_phy_err, stat_len
  );
endinterface

// File: rtl/eth_rx_fcs_check.sv
// Receive-side Ethernet FCS checker.
// Runs the byte-wise CRC-32 over every byte of a frame (FCS included) and
// compares the final register against the good-frame residue. A 4-byte delay
// buffer holds back the trailing FCS so only payload is forwarded. At the
// closing byte a one-cycle status strobe reports CRC, runt, giant and PHY
// error results together with the (saturating) frame length.
// Ports:
//   clk  : clock
//   rst  : asynchronous active-high reset
//   bus  : eth_rx_fcs_check_if.slave (rx_* in, out_* and stat_* out)
module eth_rx_fcs_check #(
  parameter int MIN_LEN = 64,
  parameter int MAX_LEN = 1518,
  parameter int LW      = 11
) (
  input  logic              clk,
  input  logic              rst,
  eth_rx_fcs_check_if.slave bus
);

  localparam logic [31:0]   CRC_POLY    = 32'h04C11DB7;
  localparam logic [31:0]   CRC_INIT    = 32'hFFFFFFFF;
  localparam logic [31:0]   CRC_RESIDUE = 32'hC704DD7B;
  localparam logic [LW-1:0] LEN_SAT     = '1;

  typedef enum logic {IDLE, RECV} state_t;

  state_t          state_q, state_d;
  logic [31:0]     crc_q, crc_d;
  logic [LW-1:0]   len_q, len_d;
  logic            phy_q, phy_d;
  logic [3:0][7:0] buf_q, buf_d;   // [3] is the oldest byte
  logic [2:0]      fill_q, fill_d;

  logic            accept;
  logic            close_frame;
  logic            push;
  logic            crc_err_d, runt_d, giant_d, ok_d;

  logic [7:0]      out_data_q;
  logic            out_valid_q, out_last_q;
  logic            stat_valid_q, stat_ok_q, stat_crc_err_q;
  logic            stat_runt_q, stat_giant_q, stat_phy_err_q;
  logic [LW-1:0]   stat_len_q;

  // Feeding data[0] first into the MSB-first shift register is the same as
  // bit-reversing the byte and then doing the parallel MSB-first update.
  function automatic logic [31:0] crc_byte(input logic [31:0] crc, input logic [7:0] data);
    logic [31:0] c;
    c = crc;
    for (int i = 0; i < 8; i++) begin
      if (c[31] ^ data[i]) c = {c[30:0], 1'b0} ^ CRC_POLY;
      else                 c = {c[30:0], 1'b0};
    end
    return c;
  endfunction

  assign accept      = bus.rx_valid;
  assign close_frame = bus.rx_valid & bus.rx_last;

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Next-state logic: a single-byte frame closes straight out of IDLE.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept && !bus.rx_last) state_d = RECV;
      RECV:    if (close_frame)            state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Output/datapath logic: CRC, length, PHY flag and strip-buffer updates.
  always_comb begin
    crc_d  = crc_q;
    len_d  = len_q;
    phy_d  = phy_q;
    fill_d = fill_q;
    buf_d  = buf_q;
    push   = 1'b0;
    if (accept) begin
      buf_d = {buf_q[2:0], bus.rx_data};
      if (state_q == IDLE) begin
        crc_d  = crc_byte(CRC_INIT, bus.rx_data);
        len_d  = LW'(1);
        phy_d  = bus.rx_er;
        fill_d = 3'd1;
      end else begin
        crc_d  = crc_byte(crc_q, bus.rx_data);
        len_d  = (len_q == LEN_SAT) ? len_q : len_q + LW'(1);
        phy_d  = phy_q | bus.rx_er;
        // Once four bytes are held, each new byte evicts the oldest as payload.
        if (fill_q == 3'd4) push = 1'b1;
        else                fill_d = fill_q + 3'd1;
      end
    end
  end

  // Close-time results are taken from the next-state values so the closing
  // byte is included in both the residue and the length.
  assign crc_err_d = (crc_d != CRC_RESIDUE);
  assign runt_d    = (int'(len_d) < MIN_LEN);
  assign giant_d   = (int'(len_d) > MAX_LEN);
  assign ok_d      = ~(crc_err_d | runt_d | giant_d | phy_d);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      crc_q  <= CRC_INIT;
      len_q  <= '0;
      phy_q  <= 1'b0;
      fill_q <= 3'd0;
      buf_q  <= '0;
    end else begin
      crc_q  <= crc_d;
      len_q  <= len_d;
      phy_q  <= phy_d;
      fill_q <= fill_d;
      buf_q  <= buf_d;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_data_q     <= 8'h00;
      out_valid_q    <= 1'b0;
      out_last_q     <= 1'b0;
      stat_valid_q   <= 1'b0;
      stat_ok_q      <= 1'b0;
      stat_crc_err_q <= 1'b0;
      stat_runt_q    <= 1'b0;
      stat_giant_q   <= 1'b0;
      stat_phy_err_q <= 1'b0;
      stat_len_q     <= '0;
    end else begin
      out_valid_q  <= push;
      out_last_q   <= push & close_frame;
      if (push) out_data_q <= buf_q[3];
      stat_valid_q <= close_frame;
      if (close_frame) begin
        stat_ok_q      <= ok_d;
        stat_crc_err_q <= crc_err_d;
        stat_runt_q    <= runt_d;
        stat_giant_q   <= giant_d;
        stat_phy_err_q <= phy_d;
        stat_len_q     <= len_d;
      end
    end
  end

  assign bus.out_data     = out_data_q;
  assign bus.out_valid    = out_valid_q;
  assign bus.out_last     = out_last_q;
  assign bus.stat_valid   = stat_valid_q;
  assign bus.stat_ok      = stat_ok_q;
  assign bus.stat_crc_err = stat_crc_err_q;
  assign bus.stat_runt    = stat_runt_q;
  assign bus.stat_giant   = stat_giant_q;
  assign bus.stat_phy_err = stat_phy_err_q;
  assign bus.stat_len     = stat_len_q;

endmodule

// File: tb/tb_eth_rx_fcs_check.sv
// Bench for eth_rx_fcs_check: two instances share one input stream, one with
// default lengths and one with MIN_LEN=4. Expected results come from a
// reflected (right-shifting) CRC-32 reference and plain length arithmetic.
module tb_eth_rx_fcs_check;
  localparam int LW = 11;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  eth_rx_fcs_check_if #(.LW(LW)) bus ();
  eth_rx_fcs_check_if #(.LW(LW)) bus4 ();

  assign bus4.rx_data  = bus.rx_data;
  assign bus4.rx_valid = bus.rx_valid;
  assign bus4.rx_last  = bus.rx_last;
  assign bus4.rx_er    = bus.rx_er;

  eth_rx_fcs_check #(.MIN_LEN(64), .MAX_LEN(1518), .LW(LW)) dut (
    .clk(clk), .rst(rst), .bus(bus));
  eth_rx_fcs_check #(.MIN_LEN(4), .MAX_LEN(1518), .LW(LW)) dut4 (
    .clk(clk), .rst(rst), .bus(bus4));

  typedef struct packed {
    logic          ok, crc, runt, giant, phy, with_last;
    logic [LW-1:0] len;
  } stat_t;

  logic [8:0]  out_q[$];      // {out_last, out_data}
  stat_t       st_q[$];
  stat_t       st4_q[$];
  int          lat_bad = 0;
  int          checks  = 0;
  int          errors  = 0;
  logic [7:0]  frm[$];
  logic [7:0]  saved[$];

  // Monitor: sample just after each active edge; inputs only change on the
  // falling edge, so rx_valid still shows the byte accepted at this edge.
  always @(posedge clk) begin
    #1;
    if (bus.out_valid) begin
      out_q.push_back({bus.out_last, bus.out_data});
      if (!bus.rx_valid) lat_bad++;
    end else if (bus.out_last) begin
      lat_bad++;
    end
    if (bus.stat_valid)
      st_q.push_back(stat_t'{bus.stat_ok, bus.stat_crc_err, bus.stat_runt, bus.stat_giant,
                             bus.stat_phy_err, bus.out_last, bus.stat_len});
    if (bus4.stat_valid)
      st4_q.push_back(stat_t'{bus4.stat_ok, bus4.stat_crc_err, bus4.stat_runt, bus4.stat_giant,
                              bus4.stat_phy_err, bus4.out_last, bus4.stat_len});
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reflected CRC-32 register over the first n bytes, no final inversion.
  function automatic logic [31:0] crc_ref(input logic [7:0] f[$], input int n);
    logic [31:0] r;
    r = 32'hFFFFFFFF;
    for (int i = 0; i < n; i++) begin
      r = r ^ {24'h0, f[i]};
      for (int b = 0; b < 8; b++) r = r[0] ? ((r >> 1) ^ 32'hEDB88320) : (r >> 1);
    end
    return r;
  endfunction

  task automatic build(input int npay, input bit zeros);
    logic [31:0] c;
    frm.delete();
    for (int i = 0; i < npay; i++) frm.push_back(zeros ? 8'h00 : 8'($urandom));
    c = ~crc_ref(frm, npay);
    frm.push_back(c[7:0]);
    frm.push_back(c[15:8]);
    frm.push_back(c[23:16]);
    frm.push_back(c[31:24]);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      bus.rx_valid = 1'b0;
      bus.rx_last  = 1'b0;
      bus.rx_er    = 1'b0;
    end
  endtask

  // Sends up to 'stop_after' bytes of f; gap cycles carry junk on the
  // qualifier-gated inputs.
  task automatic send(input logic [7:0] f[$], input int gap_pct, input int er_at, input int stop_after);
    for (int i = 0; i < f.size() && i < stop_after; i++) begin
      while (int'($urandom_range(99)) < gap_pct) begin
        @(negedge clk);
        bus.rx_valid = 1'b0;
        bus.rx_last  = 1'($urandom);
        bus.rx_er    = 1'($urandom);
        bus.rx_data  = 8'($urandom);
      end
      @(negedge clk);
      bus.rx_valid = 1'b1;
      bus.rx_data  = f[i];
      bus.rx_last  = (i == f.size() - 1);
      bus.rx_er    = (i == er_at);
    end
  endtask

  task automatic check_stat(input string tag, input bit is4, input logic [7:0] f[$], input int er_at);
    int    n;
    logic  crc_bad, runt, giant, phy;
    stat_t s;
    n       = f.size();
    crc_bad = (crc_ref(f, n) != 32'hDEBB20E3);
    runt    = n < (is4 ? 4 : 64);
    giant   = n > 1518;
    phy     = (er_at >= 0) && (er_at < n);
    chk({tag, ".stat_present"}, is4 ? (st4_q.size() > 0) : (st_q.size() > 0), 1);
    if ((is4 && st4_q.size() > 0) || (!is4 && st_q.size() > 0)) begin
      s = is4 ? st4_q.pop_front() : st_q.pop_front();
      chk({tag, ".ok"},        s.ok, !(crc_bad || runt || giant || phy));
      chk({tag, ".crc_err"},   s.crc, crc_bad);
      chk({tag, ".runt"},      s.runt, runt);
      chk({tag, ".giant"},     s.giant, giant);
      chk({tag, ".phy_err"},   s.phy, phy);
      chk({tag, ".len"},       s.len, (n > 2047) ? 2047 : n);
      chk({tag, ".with_last"}, s.with_last, n > 4);
    end
  endtask

  task automatic check_frame(input string tag, input logic [7:0] f[$], input int er_at);
    int npay, got, first_bad, nlast, lastpos;
    logic [8:0] w;
    npay      = (f.size() > 4) ? f.size() - 4 : 0;
    got       = 0;
    first_bad = -1;
    nlast     = 0;
    lastpos   = -1;
    for (int i = 0; i < npay; i++) begin
      if (out_q.size() > 0) begin
        w = out_q.pop_front();
        got++;
        if (w[7:0] !== f[i] && first_bad < 0) first_bad = i;
        if (w[8]) begin
          nlast++;
          lastpos = i;
        end
      end
    end
    chk({tag, ".payload_cnt"}, got, npay);
    chk({tag, ".payload_bad_idx"}, first_bad, -1);
    chk({tag, ".last_cnt"}, nlast, (npay > 0) ? 1 : 0);
    if (npay > 0) chk({tag, ".last_pos"}, lastpos, npay - 1);
    check_stat({tag, ".d64"}, 1'b0, f, er_at);
    check_stat({tag, ".d4"},  1'b1, f, er_at);
  endtask

  task automatic chk_empty(input string tag);
    chk({tag, ".extra_out"},  out_q.size(), 0);
    chk({tag, ".extra_stat"}, st_q.size(), 0);
    chk({tag, ".extra_st4"},  st4_q.size(), 0);
    chk({tag, ".stray_out"},  lat_bad, 0);
  endtask

  initial begin
    int er_at, bad;
    bus.rx_valid = 1'b0;
    bus.rx_last  = 1'b0;
    bus.rx_er    = 1'b0;
    bus.rx_data  = 8'h00;
    repeat (3) @(negedge clk);
    chk("rst.out_data",   bus.out_data, 0);
    chk("rst.out_valid",  bus.out_valid, 0);
    chk("rst.out_last",   bus.out_last, 0);
    chk("rst.stat_valid", bus.stat_valid, 0);
    chk("rst.flags",      {bus.stat_ok, bus.stat_crc_err, bus.stat_runt, bus.stat_giant, bus.stat_phy_err}, 0);
    chk("rst.stat_len",   bus.stat_len, 0);
    chk("rst.d4_flags",   {bus4.stat_valid, bus4.stat_ok, bus4.out_valid, bus4.stat_len}, 0);
    rst = 1'b0;

    // Standard check vector: "123456789" + its FCS.
    frm = '{8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37, 8'h38, 8'h39,
            8'h26, 8'h39, 8'hF4, 8'hCB};
    send(frm, 0, -1, 100000);
    idle(4);
    check_frame("vec_good", frm, -1);
    chk_empty("vec_good");

    frm[4] = 8'h34;
    send(frm, 0, -1, 100000);
    idle(4);
    check_frame("vec_bad", frm, -1);
    chk_empty("vec_bad");

    build(60, 1'b1);
    send(frm, 30, -1, 100000);
    idle(4);
    check_frame("min64", frm, -1);
    chk_empty("min64");

    build(59, 1'b1);
    send(frm, 30, -1, 100000);
    idle(4);
    check_frame("runt63", frm, -1);
    chk_empty("runt63");

    // 1518 then 1519 bytes with no idle cycle between them.
    build(1514, 1'b0);
    saved = frm;
    send(saved, 0, -1, 100000);
    build(1515, 1'b0);
    send(frm, 0, -1, 100000);
    idle(4);
    chk("b2b.stat_pulses", st_q.size(), 2);
    check_frame("max1518", saved, -1);
    check_frame("giant1519", frm, -1);
    chk_empty("b2b");

    build(60, 1'b0);
    send(frm, 20, 9, 100000);
    idle(4);
    check_frame("phy_err", frm, 9);
    chk_empty("phy_err");

    frm.delete();
    for (int i = 0; i < 3; i++) frm.push_back(8'($urandom));
    send(frm, 0, -1, 100000);
    idle(4);
    check_frame("len3", frm, -1);
    chk_empty("len3");

    // Abort after 20 bytes: 16 payload bytes leave before reset, no status.
    build(60, 1'b0);
    send(frm, 0, -1, 20);
    @(negedge clk);
    bus.rx_valid = 1'b0;
    bus.rx_last  = 1'b0;
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    idle(2);
    chk("abort.out_cnt", out_q.size(), 16);
    bad = 0;
    for (int i = 0; i < 16 && out_q.size() > 0; i++) begin
      logic [8:0] w;
      w = out_q.pop_front();
      if (w !== {1'b0, frm[i]}) bad++;
    end
    chk("abort.out_bytes", bad, 0);
    chk_empty("abort");

    build(60, 1'b0);
    send(frm, 25, -1, 100000);
    idle(4);
    check_frame("after_abort", frm, -1);
    chk_empty("after_abort");

    // Randomised frames: random length, optional corruption and PHY error.
    for (int k = 0; k < 8; k++) begin
      build($urandom_range(0, 90), 1'b0);
      if ($urandom_range(1) == 1) frm[$urandom_range(frm.size() - 1)] ^= 8'($urandom_range(1, 255));
      er_at = ($urandom_range(3) == 0) ? int'($urandom_range(frm.size() - 1)) : -1;
      send(frm, 25, er_at, 100000);
      if ($urandom_range(1) == 1) idle(3);
      idle(3);
      check_frame($sformatf("rand%0d", k), frm, er_at);
      chk_empty($sformatf("rand%0d", k));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
